keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad (active-low row drive, active-low column sense) and encodes each

---
 rtl/keypad_scanner.sv | 265 ++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-level debounce, hex key encoding and a 32-bit digit register.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  col_n,
  input  logic        clear,
  output logic [3:0]  row_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [31:0] digits
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE = 2'd0, RES_KEY = 2'd1, RES_MULTI = 2'd2} frame_res_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_PRESSED = 1'b1} state_t;

  function automatic logic [2:0] count_low(input logic [3:0] v);
    count_low = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    if (v[0])      low_index = 2'd0;
    else if (v[1]) low_index = 2'd1;
    else if (v[2]) low_index = 2'd2;
    else           low_index = 2'd3;
  endfunction

  logic [3:0]        col_meta_r, col_sync_r;
  logic [SLOT_W-1:0] slot_cnt_r;
  logic [1:0]        row_idx_r;
  logic [3:0]        row_n_r;
  logic [1:0]        acc_cnt_r;
  logic [3:0]        acc_code_r;
  frame_res_t        prev_kind_r, frame_kind_s;
  logic [3:0]        prev_code_r, frame_code_s;
  logic [STAB_W-1:0] stab_r, stab_next_s;
  state_t            state_r, state_next_s;
  logic              key_valid_r, key_held_r;
  logic [3:0]        key_code_r;
  logic [31:0]       digits_r;

  logic              slot_last_s, frame_tick_s, same_s, debounced_s;
  logic              press_s, rep_fire_s, emit_s;
  logic [3:0]        col_low_s, row_code_s;
  logic [2:0]        row_pop_s, acc_sum_s;
  logic [1:0]        acc_sat_s;

  // Two-flop synchronizer; idles released so no phantom press follows reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= col_n;
      col_sync_r <= col_meta_r;
    end
  end

  // Slot timer and row rotation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_cnt_r <= '0;
      row_idx_r  <= 2'd0;
      row_n_r    <= 4'b1110;
    end else if (slot_last_s) begin
      slot_cnt_r <= '0;
      row_idx_r  <= row_idx_r + 2'd1;
      row_n_r    <= {row_n_r[2:0], row_n_r[3]};
    end else begin
      slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
      row_idx_r  <= row_idx_r;
      row_n_r    <= row_n_r;
    end
  end

  // Per-row sample decode and whole-frame classification.
  always_comb begin
    slot_last_s  = (slot_cnt_r == SLOT_LAST);
    frame_tick_s = slot_last_s && (row_idx_r == 2'd3);
    col_low_s    = ~col_sync_r;
    row_pop_s    = count_low(col_low_s);
    row_code_s   = {row_idx_r, low_index(col_low_s)};
    acc_sum_s    = {1'b0, acc_cnt_r} + row_pop_s;
    acc_sat_s    = (acc_sum_s >= 3'd2) ? 2'd2 : acc_sum_s[1:0];
    frame_kind_s = RES_NONE;
    frame_code_s = 4'h0;
    if (acc_sat_s == 2'd0) begin
      frame_kind_s = RES_NONE;
    end else if (acc_sat_s == 2'd1) begin
      frame_kind_s = RES_KEY;
      frame_code_s = (row_pop_s == 3'd1) ? row_code_s : acc_code_r;
    end else begin
      frame_kind_s = RES_MULTI;
    end
    same_s      = (frame_kind_s == prev_kind_r) &&
                  ((frame_kind_s != RES_KEY) || (frame_code_s == prev_code_r));
    if (!same_s) begin
      stab_next_s = STAB_W'(1);
    end else if (stab_r == STAB_MAX) begin
      stab_next_s = STAB_MAX;
    end else begin
      stab_next_s = stab_r + STAB_W'(1);
    end
    debounced_s = frame_tick_s && (stab_next_s == STAB_MAX);
  end

  // Frame accumulator, restarted after every row-3 sample.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'h0;
    end else if (frame_tick_s) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'h0;
    end else if (slot_last_s) begin
      acc_cnt_r  <= acc_sat_s;
      acc_code_r <= (row_pop_s == 3'd1) ? row_code_s : acc_code_r;
    end else begin
      acc_cnt_r  <= acc_cnt_r;
      acc_code_r <= acc_code_r;
    end
  end

  // Stability counter against the previous frame result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_kind_r <= RES_NONE;
      prev_code_r <= 4'h0;
      stab_r      <= '0;
    end else if (frame_tick_s) begin
      prev_kind_r <= frame_kind_s;
      prev_code_r <= frame_code_s;
      stab_r      <= stab_next_s;
    end else begin
      prev_kind_r <= prev_kind_r;
      prev_code_r <= prev_code_r;
      stab_r      <= stab_r;
    end
  end

  // Press/release FSM next state; a new key is only accepted from IDLE.
  always_comb begin
    state_next_s = state_r;
    press_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (debounced_s && (frame_kind_s == RES_KEY)) begin
          state_next_s = ST_PRESSED;
          press_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (debounced_s && (frame_kind_s == RES_NONE)) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PRESSED;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_C = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RATE_C  = REP_W'(REPEAT_RATE);

  logic [REP_W-1:0] rep_cnt_r, rep_inc_s;
  logic             rep_first_r, rep_same_s;

  // Repeat decision: first repeat after REPEAT_DELAY frames, then every REPEAT_RATE.
  always_comb begin
    rep_inc_s  = rep_cnt_r + REP_W'(1);
    rep_same_s = debounced_s && (state_r == ST_PRESSED) &&
                 (frame_kind_s == RES_KEY) && (frame_code_s == key_code_r);
    if (!rep_same_s) begin
      rep_fire_s = 1'b0;
    end else if (rep_first_r) begin
      rep_fire_s = (rep_inc_s == REP_DELAY_C);
    end else begin
      rep_fire_s = (rep_inc_s == REP_RATE_C);
    end
  end

  // Repeat frame counter; any frame other than the debounced held key restarts the delay.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rep_cnt_r   <= '0;
      rep_first_r <= 1'b1;
    end else if (press_s) begin
      rep_cnt_r   <= '0;
      rep_first_r <= 1'b1;
    end else if (frame_tick_s) begin
      if (rep_fire_s) begin
        rep_cnt_r   <= '0;
        rep_first_r <= 1'b0;
      end else if (rep_same_s) begin
        rep_cnt_r   <= rep_inc_s;
        rep_first_r <= rep_first_r;
      end else begin
        rep_cnt_r   <= '0;
        rep_first_r <= 1'b1;
      end
    end else begin
      rep_cnt_r   <= rep_cnt_r;
      rep_first_r <= rep_first_r;
    end
  end
`else
  logic [63:0] unused_repeat_cfg;
  assign unused_repeat_cfg = {REPEAT_DELAY, REPEAT_RATE};
  assign rep_fire_s = 1'b0;
`endif

  assign emit_s = press_s | rep_fire_s;

  // FSM state and key outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      key_valid_r <= 1'b0;
      key_code_r  <= 4'h0;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      key_valid_r <= emit_s;
      key_code_r  <= press_s ? frame_code_s : key_code_r;
      key_held_r  <= (state_next_s == ST_PRESSED);
    end
  end

  // Digit shift register; clear wins over a simultaneous shift.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits_r <= 32'h0;
    end else if (clear) begin
      digits_r <= 32'h0;
    end else if (key_valid_r) begin
      digits_r <= {digits_r[27:0], key_code_r};
    end else begin
      digits_r <= digits_r;
    end
  end

  assign row_n     = row_n_r;
  assign key_valid = key_valid_r;
  assign key_code  = key_code_r;
  assign key_held  = key_held_r;
  assign digits    = digits_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: key matrix patterns applied per scan frame and
// compared against a frame-level reference model of debounce, press/release and digit entry.
module tb_keypad_scanner;
  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int RD    = 4;
  localparam int RR    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [31:0] digits;
  logic [15:0] key_mat = 16'h0;
  logic [3:0]  last_row = 4'b1110;

  int          n_tests = 0;
  int          n_fail = 0;

  // reference model state (frame granularity)
  int          m_stab, m_prev_kind, m_hold;
  logic [3:0]  m_prev_code, m_code;
  logic        m_held, m_kv;
  logic [31:0] m_digits;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .reset_n(reset_n), .col_n(col_n), .clear(clear), .row_n(row_n),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held), .digits(digits)
  );

  always #5 clk = ~clk;

  // A closed switch pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && key_mat[r*4+c]) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_stab = 0; m_prev_kind = 0; m_prev_code = 4'h0; m_code = 4'h0;
    m_held = 1'b0; m_kv = 1'b0; m_hold = 0; m_digits = 32'h0;
  endtask

  task automatic model_frame(input logic [15:0] pat);
    int         pc, kind;
    logic [3:0] code;
    bit         deb;
    pc   = $countones(pat);
    kind = (pc == 0) ? 0 : ((pc == 1) ? 1 : 2);
    code = 4'h0;
    if (kind == 1) begin
      for (int i = 0; i < 16; i++) if (pat[i]) code = 4'(i);
    end
    if (kind == m_prev_kind && (kind != 1 || code == m_prev_code)) m_stab = (m_stab + 1 > DB) ? DB : m_stab + 1;
    else m_stab = 1;
    m_prev_kind = kind;
    m_prev_code = code;
    deb  = (m_stab >= DB);
    m_kv = 1'b0;
    if (!m_held) begin
      if (deb && kind == 1) begin
        m_held = 1'b1; m_kv = 1'b1; m_code = code; m_hold = 0;
      end
    end else if (deb && kind == 0) begin
      m_held = 1'b0; m_hold = 0;
    end
`ifdef KEYPAD_REPEAT_EN
    else if (deb && kind == 1 && code == m_code) begin
      m_hold++;
      if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RR == 0)) m_kv = 1'b1;
    end else begin
      m_hold = 0;
    end
`endif
    if (m_kv) m_digits = {m_digits[27:0], m_code};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; key_mat = 16'h0; clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_row_n", {28'h0, row_n}, 32'hE);
    check_val("rst_key_valid", {31'h0, key_valid}, 32'h0);
    check_val("rst_key_held", {31'h0, key_held}, 32'h0);
    check_val("rst_key_code", {28'h0, key_code}, 32'h0);
    check_val("rst_digits", digits, 32'h0);
    reset_n = 1'b1;
    last_row = 4'b1110;
    model_reset();
    model_frame(key_mat);
  endtask

  task automatic next_frame();
    bit found = 1'b0;
    for (int i = 0; i < FRAME + 4 && !found; i++) begin
      @(negedge clk);
      if (row_n == 4'b1110 && last_row != 4'b1110) found = 1'b1;
      last_row = row_n;
    end
    check_val("frame_sync", {31'h0, found}, 32'h1);
  endtask

  // One scan frame: check outputs produced by the previous frame, then apply this frame's pattern.
  task automatic run_frame(input logic [15:0] pat, input bit do_clr);
    int         kv_extra;
    logic [3:0] r1, r2, r3;
    next_frame();
    check_val("key_valid", {31'h0, key_valid}, {31'h0, m_kv});
    check_val("key_code", {28'h0, key_code}, {28'h0, m_code});
    check_val("key_held", {31'h0, key_held}, {31'h0, m_held});
    if (do_clr) begin
      clear = 1'b1;
      m_digits = 32'h0;
    end
    key_mat = pat;
    kv_extra = 0;
    r1 = 4'h0; r2 = 4'h0; r3 = 4'h0;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      last_row = row_n;
      if (i == 1) begin
        clear = 1'b0;
        check_val("digits", digits, m_digits);
      end
      if (key_valid) kv_extra++;
      if (i == SD) r1 = row_n;
      if (i == 2 * SD) r2 = row_n;
      if (i == 3 * SD) r3 = row_n;
    end
    check_val("kv_mid_frame", kv_extra, 32'h0);
    check_val("row_walk", {20'h0, r1, r2, r3}, 32'hDB7);
    model_frame(pat);
  endtask

  task automatic hold(input logic [15:0] pat, input int frames);
    for (int f = 0; f < frames; f++) run_frame(pat, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    int          sel, a, b, len;
    do_reset();
    hold(16'h0, 3);
    // row2/col1 held 4 frames, then released
    hold(16'h0200, 4);
    check_val("digits_key9", digits, 32'h00000009);
    check_val("held_key9", {31'h0, key_held}, 32'h1);
    hold(16'h0, 3);
    // single-frame bounce
    hold(16'h0020, 1);
    hold(16'h0, 3);
    // row0/col0 + row1/col0 together
    hold(16'h0011, 6);
    hold(16'h0, 3);
    for (int k = 1; k <= 9; k++) begin
      pat = 16'h0001 << k;
      hold(pat, 3);
      hold(16'h0, 2);
    end
    check_val("digits_nine", digits, 32'h23456789);
    // 10th press with clear in its key_valid cycle
    hold(16'h0400, 2);
    run_frame(16'h0400, 1'b1);
    hold(16'h0400, 1);
    check_val("digits_cleared", digits, 32'h0);
    hold(16'h0, 3);
    // long hold (auto-repeat when enabled)
    hold(16'h4000, 12);
    hold(16'h0, 3);
    // randomized patterns and durations
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        pat = 16'h0;
      end else if (sel < 8) begin
        pat = 16'h0001 << $urandom_range(0, 15);
      end else begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        pat = (16'h0001 << a) | (16'h0001 << b);
      end
      len = $urandom_range(1, 5);
      for (int f = 0; f < len; f++) run_frame(pat, ($urandom_range(0, 19) == 0));
    end
    // reset in the middle of a press
    hold(16'h0008, 3);
    do_reset();
    hold(16'h0, 2);
    hold(16'h0080, 3);
    hold(16'h0, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
